// File: rtl/vctcxo_dac_pkg.sv
// Shared types and constants for the VCTCXO tuning DAC arbiter.
// AD5662 frame layout, power-down encodings and arbiter states.
package vctcxo_dac_pkg;

    localparam int FRAME_BITS = 24;

    typedef enum logic [1:0] {
        NORMAL      = 2'b00,
        PD_1K       = 2'b01,
        PD_100K     = 2'b10,
        PD_TRISTATE = 2'b11
    } pd_mode_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } arb_state_e;

    function automatic logic [FRAME_BITS-1:0] frame_word(
        input pd_mode_e    pd,
        input logic [15:0] code
    );
        return {6'b0, pd, code};
    endfunction

endpackage

// File: rtl/ad5662_spi_shifter.sv
// Serialises one 24-bit AD5662 frame, MSB first, DAC samples on sclk fall.
// done is high in the last low-phase cycle so the caller can latch in step.
module ad5662_spi_shifter
    import vctcxo_dac_pkg::*;
#(
    parameter int SCLK_DIV = 2
) (
    input  logic                  refclk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] word,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  sync_n
);

    localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

    logic                  active;
    logic                  high;
    logic [DW-1:0]         div;
    logic [4:0]            bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic                  half_end;

    assign half_end = (div == DIV_LAST);
    assign done     = active & ~high & half_end & (bit_cnt == 5'd0);

    always_ff @(posedge refclk) begin
        if (reset) begin
            active  <= 1'b0;
            high    <= 1'b0;
            div     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sclk    <= 1'b1;
            mosi    <= 1'b0;
            sync_n  <= 1'b1;
        end else if (start && !active) begin
            active  <= 1'b1;
            high    <= 1'b1;
            div     <= '0;
            bit_cnt <= 5'(FRAME_BITS - 1);
            shreg   <= word << 1;
            mosi    <= word[FRAME_BITS-1];
            sclk    <= 1'b1;
            sync_n  <= 1'b0;
        end else if (active) begin
            if (!half_end) begin
                div <= div + 1'b1;
            end else begin
                div <= '0;
                if (high) begin
                    high <= 1'b0;
                    sclk <= 1'b0;
                end else if (bit_cnt == 5'd0) begin
                    // Last bit sampled: release the line to idle.
                    active <= 1'b0;
                    sclk   <= 1'b1;
                    sync_n <= 1'b1;
                    mosi   <= 1'b0;
                end else begin
                    high    <= 1'b1;
                    sclk    <= 1'b1;
                    mosi    <= shreg[FRAME_BITS-1];
                    shreg   <= shreg << 1;
                    bit_cnt <= bit_cnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vctcxo_dac_arbiter.sv
// Two-writer arbiter for the AD5662 VCTCXO tuning DAC (host over loop).
// Writes INIT_VALUE after every reset, then one frame per accepted request.
module vctcxo_dac_arbiter
    import vctcxo_dac_pkg::*;
#(
    parameter int          SCLK_DIV   = 2,
    parameter int          SYNC_GAP   = 2,
    parameter logic [15:0] INIT_VALUE = 16'd32767,
    parameter pd_mode_e    PD_MODE    = NORMAL
) (
    input  logic        refclk,
    input  logic        reset,
    input  logic [15:0] loop_dat,
    input  logic        loop_valid,
    output logic        loop_ready,
    input  logic [15:0] host_dat,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic        host_override,
    output logic        busy,
    output logic [15:0] dac_value,
    output logic        sclk,
    output logic        mosi,
    output logic        sync_n
);

    localparam int GW = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'(SYNC_GAP - 1);

    arb_state_e  state;
    logic [GW-1:0] gap_cnt;
    logic [15:0] code_q;
    logic [15:0] code_next;
    logic        start;
    logic        done;

    always_comb begin
        start     = 1'b0;
        code_next = INIT_VALUE;
        unique case (1'b1)
            state == ST_INIT: begin
                start = 1'b1;
            end
            state == ST_IDLE && host_valid: begin
                start     = 1'b1;
                code_next = host_dat;
            end
            state == ST_IDLE && !host_valid
                && loop_valid && !host_override: begin
                start     = 1'b1;
                code_next = loop_dat;
            end
            default: ;
        endcase
    end

    // Override sinks loop traffic everywhere; otherwise host wins in IDLE.
    assign loop_ready = ~reset
                      & (host_override | (host_ready & ~host_valid));

    always_ff @(posedge refclk) begin
        if (reset) begin
            state      <= ST_INIT;
            gap_cnt    <= '0;
            code_q     <= '0;
            busy       <= 1'b0;
            host_ready <= 1'b0;
            dac_value  <= '0;
        end else begin
            unique case (state)
                ST_INIT: begin
                    code_q <= code_next;
                    state  <= ST_SHIFT;
                    busy   <= 1'b1;
                end
                ST_IDLE: begin
                    if (start) begin
                        code_q     <= code_next;
                        state      <= ST_SHIFT;
                        busy       <= 1'b1;
                        host_ready <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (done) begin
                        dac_value <= code_q;
                        gap_cnt   <= '0;
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        host_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    ad5662_spi_shifter #(
        .SCLK_DIV (SCLK_DIV)
    ) u_shifter (
        .refclk (refclk),
        .reset  (reset),
        .start  (start),
        .word   (frame_word(PD_MODE, code_next)),
        .done   (done),
        .sclk   (sclk),
        .mosi   (mosi),
        .sync_n (sync_n)
    );

endmodule

// File: doc/vctcxo_dac_arbiter.md
# vctcxo_dac_arbiter

Shares the single AD5662 VCTCXO tuning DAC between two writers: the reference-PLL loop filter output and a host/software override path. Arbitrates per-frame with valid/ready handshakes, and writes a power-on init code after reset. Serialises each accepted 16-bit code into a 24-bit AD5662 SPI frame. Runs entirely on refclk (40 MHz); both request ports are already synchronous to refclk.

## Interface
- SCLK_DIV, 2: refclk cycles per sclk half-period (≥1).
- SYNC_GAP, 2: refclk cycles sync_n held high between frames (≥1).
- INIT_VALUE, 16'd32767: DAC code written once after reset (mid-scale).
- PD_MODE, 2'b00: AD5662 power-down bits placed in every frame (00 = normal).
- refclk  in  1  clock
- reset  in  1  synchronous, active-high
- loop_dat  in  16  code from PLL loop
- loop_valid  in  1  loop request
- loop_ready  out  1  loop accept
- host_dat  in  16  code from host register
- host_valid  in  1  host request
- host_ready  out  1  host accept
- host_override  in  1  1 = loop requests are sunk and discarded
- busy  out  1  frame (init, shift or gap) in progress
- dac_value  out  16  last code fully shifted to the DAC
- sclk  out  1  SPI clock to AD5662
- mosi  out  1  SPI data, MSB first
- sync_n  out  1  SPI frame select, active low

Reset: synchronous, active-high; clock: refclk.

## Operation
- FSM states:
  - INIT: load INIT_VALUE, go to SHIFT.
  - IDLE: arbitrate requests.
  - SHIFT: 24 bits on the wire.
  - GAP: SYNC_GAP cycles with sync_n high, then IDLE.
- Arbitration happens in IDLE only.
  - host_ready = 1 in IDLE; loop_ready = 1 in IDLE and host_override = 0.
  - Fixed priority: host over loop. If both are valid in IDLE, host is accepted and loop_ready is 0 that cycle.
  - With host_override = 1, loop_ready = 1 in every state and loop transfers are discarded (never shifted).
- Frame word is {6'b0, PD_MODE, code}, bits 23..0, MSB first.
- Per bit:
  - At the start of the high phase, mosi is set and sclk is 1 for SCLK_DIV cycles.
  - sclk is then 0 for SCLK_DIV cycles.
  - The DAC samples on the falling edge.
- After bit 0's low phase:
  - sync_n returns to 1 and sclk to 1.
  - dac_value ← code in the same cycle.
  - Enter GAP.
- Idle line state: sync_n = 1, sclk = 1, mosi = 0.
- Reset mid-frame: the next edge forces the idle line state. The AD5662 discards a frame aborted by early sync_n rise. dac_value is cleared, and INIT repeats after reset deasserts.
- A request held while busy waits with valid high. A request dropped before acceptance is lost; there is no queueing.

## Timing
- Reset values:
  - sync_n = 1, sclk = 1, mosi = 0.
  - loop_ready = 0, host_ready = 0.
  - busy = 0, dac_value = 16'd0.
- The first cycle after reset deasserts is INIT.
  - busy = 1 and sync_n = 0 from the following cycle.
  - mosi carries bit 23 in that same cycle.
- Accept at cycle t (valid & ready):
  - sync_n falls and mosi = bit 23 at t+1.
  - The first sclk falling edge is at t+1+SCLK_DIV.
  - sync_n rises and dac_value updates at t+1+48·SCLK_DIV.
- GAP lasts SYNC_GAP cycles; ready reasserts at t+1+48·SCLK_DIV+SYNC_GAP.
  - Defaults: a 99-cycle frame-to-frame period, 2.475 µs.
- busy = (state ≠ IDLE); it deasserts in the cycle ready reasserts.
- Back-to-back: a request held valid is accepted on the first IDLE cycle. There are no bubbles beyond GAP.

## Structure
- Package vctcxo_dac_pkg holds:
  - FRAME_BITS = 24.
  - The PD_MODE encodings (NORMAL, PD_1K, PD_100K, PD_TRISTATE).
  - The arbiter state enum.
- Sub-module ad5662_spi_shifter:
  - Inputs: start, word[23:0].
  - Outputs: done pulse, sclk, mosi, sync_n.
  - Parameter SCLK_DIV.
  - Holds the bit counter and the half-period divider.
- The top level holds arbitration, INIT, GAP and dac_value.

## Test plan
- Reset release, no requests:
  - Exactly one frame 0x00_7FFF shifts out; sync_n is low for 96 cycles.
  - dac_value = 0x7FFF; busy then drops.
- Simultaneous requests in IDLE (host_dat = 0x1234, loop_dat = 0xABCD, both valid):
  - host is accepted first and frame 0x00_1234 is shifted.
  - loop is accepted 99 cycles later and frame 0x00_ABCD is shifted.
- host_override = 1 with a loop request (0x5555 valid):
  - loop_ready = 1, sync_n never falls, dac_value is unchanged.
- Bit-level check, PD_MODE = 2'b11, SCLK_DIV = 3, code 0x8001:
  - The sampled bits on sclk falling edges equal 0x03_8001.
  - The sclk period is 6 cycles.
- Reset asserted at bit 10 of a frame:
  - Next cycle: sync_n = 1, sclk = 1, dac_value = 0.
  - After release, the INIT frame 0x00_7FFF shifts.
- Loop valid held continuously with incrementing data:
  - Accepts occur exactly every 48·SCLK_DIV+SYNC_GAP+1 cycles.
  - No code is skipped while valid is held.
